// File: rtl/memory_driver_if.sv
// Bit-level command/data bus of the 8x8 memory driver.
// The controller side uses the master modport; the memory uses the slave modport.
interface memory_driver_if;
  logic i0, i1, i2, i3, i4, i5, i6, i7;
  logic addr0, addr1, addr2;
  logic select;
  logic operation;
  logic o0, o1, o2, o3, o4, o5, o6, o7;

  modport master (
    output i0, i1, i2, i3, i4, i5, i6, i7,
    output addr0, addr1, addr2,
    output select, operation,
    input  o0, o1, o2, o3, o4, o5, o6, o7
  );

  modport slave (
    input  i0, i1, i2, i3, i4, i5, i6, i7,
    input  addr0, addr1, addr2,
    input  select, operation,
    output o0, o1, o2, o3, o4, o5, o6, o7
  );
endinterface

// File: rtl/memory_driver.sv
// 8-word x 8-bit register-file memory with select/operation command decode and a
// registered read bus. Define MEMORY_DRIVER_WRITE_THROUGH_EN to echo write data on the output.
module memory_driver (
  input  logic              i_clock,
  input  logic              i_reset,
  memory_driver_if.slave    bus,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [7:0] mem [8];
  logic [7:0] out_q;
  logic [2:0] addr;
  logic [7:0] data_in;

  assign addr    = {bus.addr2, bus.addr1, bus.addr0};
  assign data_in = {bus.i7, bus.i6, bus.i5, bus.i4, bus.i3, bus.i2, bus.i1, bus.i0};

  // Anything other than a clean 1x pattern (including X/Z) falls to IDLE.
  always_comb begin
    next_state = ST_IDLE;
    case ({bus.select, bus.operation})
      2'b11:   next_state = ST_WRITE;
      2'b10:   next_state = ST_READ;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state <= ST_IDLE;
      out_q <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      state <= next_state;
      case (next_state)
        ST_WRITE: begin
          mem[addr] <= data_in;
`ifdef MEMORY_DRIVER_WRITE_THROUGH_EN
          out_q <= data_in;
`endif
        end
        ST_READ: out_q <= mem[addr];
        default: ;
      endcase
    end
  end

  assign state_dbg = state;

  assign bus.o0 = out_q[0];
  assign bus.o1 = out_q[1];
  assign bus.o2 = out_q[2];
  assign bus.o3 = out_q[3];
  assign bus.o4 = out_q[4];
  assign bus.o5 = out_q[5];
  assign bus.o6 = out_q[6];
  assign bus.o7 = out_q[7];

endmodule

// File: tb/tb_memory_driver.sv
// Bench for memory_driver: directed test plan plus randomized commands checked against
// an array-based reference memory.
module tb_memory_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg;
  int         checks = 0;
  int         failures = 0;

  logic [7:0] model_mem [8];
  logic [7:0] model_out;

  memory_driver_if bus ();

  memory_driver dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%02h exp=%02h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] get_out();
    return {bus.o7, bus.o6, bus.o5, bus.o4, bus.o3, bus.o2, bus.o1, bus.o0};
  endfunction

  task automatic set_inputs(input logic sel, input logic op, input logic [2:0] a,
                            input logic [7:0] d);
    bus.select    = sel;
    bus.operation = op;
    {bus.addr2, bus.addr1, bus.addr0} = a;
    {bus.i7, bus.i6, bus.i5, bus.i4, bus.i3, bus.i2, bus.i1, bus.i0} = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model_mem[i] = 8'h00;
    model_out = 8'h00;
  endtask

  // One command per clock: drive, take the edge, update the model, compare after the edge.
  task automatic cycle(input string tag, input logic sel, input logic op,
                       input logic [2:0] a, input logic [7:0] d);
    set_inputs(sel, op, a, d);
    @(posedge clk);
    if (sel && op) begin
      model_mem[a] = d;
`ifdef MEMORY_DRIVER_WRITE_THROUGH_EN
      model_out = d;
`endif
    end else if (sel) begin
      model_out = model_mem[a];
    end
    #1;
    check(tag, get_out(), model_out);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cycle("write", 1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input string tag, input logic [2:0] a);
    cycle(tag, 1'b1, 1'b0, a, 8'h00);
  endtask

  initial begin
    logic [7:0] seq_data [5];
    seq_data[0] = 8'h65; seq_data[1] = 8'h6C; seq_data[2] = 8'h69;
    seq_data[3] = 8'h61; seq_data[4] = 8'h73;

    // Reset with undriven inputs
    bus.select = 1'bx; bus.operation = 1'bx;
    {bus.addr2, bus.addr1, bus.addr0} = 3'bxxx;
    {bus.i7, bus.i6, bus.i5, bus.i4, bus.i3, bus.i2, bus.i1, bus.i0} = 8'hxx;
    rst = 1'b1;
    model_reset();
    #12;
    check("reset_out", get_out(), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rd("reset_read", 3'(a));
      check("reset_read_const", get_out(), 8'h00);
    end

    // Write/read sequence
    for (int a = 0; a < 5; a++) wr(3'(a), seq_data[a]);
    cycle("idle_gap", 1'b0, 1'b1, 3'd7, 8'hEE);
    for (int a = 0; a < 5; a++) begin
      rd("seq_read", 3'(a));
      check("seq_read_const", get_out(), seq_data[a]);
    end

    // Idle hold
    rd("idle_pre", 3'd1);
    for (int k = 0; k < 5; k++) begin
      cycle("idle_hold", 1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            8'($urandom_range(0, 255)));
      check("idle_hold_const", get_out(), 8'h6C);
    end
    rd("idle_reread", 3'd1);
    check("idle_reread_const", get_out(), 8'h6C);

    // Write leaves out alone unless write-through is enabled
    rd("wt_pre", 3'd0);
    check("wt_pre_const", get_out(), 8'h65);
    wr(3'd0, 8'hFF);
`ifdef MEMORY_DRIVER_WRITE_THROUGH_EN
    check("wt_after_write", get_out(), 8'hFF);
`else
    check("wt_after_write", get_out(), 8'h65);
`endif
    rd("wt_read", 3'd0);
    check("wt_read_const", get_out(), 8'hFF);

    // Overwrite and neighbour isolation
    wr(3'd1, 8'h55);
    wr(3'd1, 8'hAA);
    rd("ovw_read1", 3'd1);
    check("ovw_read1_const", get_out(), 8'hAA);
    rd("ovw_read0", 3'd0);
    check("ovw_read0_const", get_out(), 8'hFF);
    rd("ovw_read2", 3'd2);
    check("ovw_read2_const", get_out(), 8'h69);

    // Randomized commands
    for (int k = 0; k < 300; k++) begin
      cycle("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
    end

    // Reset between edges during a read burst
    for (int a = 0; a < 8; a++) wr(3'(a), 8'(8'h11 * (a + 1)));
    rd("burst", 3'd3);
    rd("burst", 3'd4);
    set_inputs(1'b1, 1'b0, 3'd5, 8'h00);
    #3;
    rst = 1'b1;
    #1;
    check("reset_mid_out", get_out(), 8'h00);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 8; a++) rd("reset_mid_read", 3'(a));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/memory_driver.md
# memory_driver

Synchronous 8-word × 8-bit register-file memory with a simple select/operation command interface and bit-level ports. It is the top-level storage block of the 8x8 memory IC: an external controller presents an address, a data byte and a command each clock, and the block writes or reads the addressed word. Read data appears on a registered output bus that holds its value between reads.

## Interface
Parameters: none (word count 8, width 8, address width 3 are fixed).

- i_clock  input  1  system clock; all state changes on rising edge
- i_reset  input  1  asynchronous, active-high reset
- i0..i7  input  1 each  write data bits; i0 = LSB, i7 = MSB
- addr0..addr2  input  1 each  word address; addr0 = LSB
- select  input  1  chip select; 0 = idle
- operation  input  1  1 = write, 0 = read (qualified by select)
- o0..o7  output  1 each  registered read data; o0 = LSB

## Operation
- Internal storage: mem[0..7], 8 bits each. Address = {addr2,addr1,addr0}; data in = {i7..i0}; data out = {o7..o0}.
- Command decode each cycle from {select, operation}:
  - select=0, any operation -> IDLE: no memory change, outputs hold.
  - select=1, operation=1 -> WRITE: mem[addr] <= data in; outputs hold.
  - select=1, operation=0 -> READ: out <= mem[addr].
- Any select or operation value other than a clean 0/1 (X/Z) decodes as IDLE.
- State register (IDLE, WRITE, READ) holds the command accepted at the last edge. Transitions: any state -> any state, chosen solely by the decode at each rising edge. No multi-cycle sequences, no handshake; one command per cycle.
- Data inputs are ignored in IDLE and READ. Address is ignored in IDLE.
- All 8 addresses are valid; there is no out-of-range case and no wrap logic.

## Timing
- Reset (asynchronous assert, deassert sampled at the next rising edge): all mem words = 0x00, out = 0x00, state = IDLE. Reset asserted mid-write or mid-read aborts the operation; memory and outputs go to 0 immediately.
- Write latency: data is stored at the rising edge on which WRITE is sampled.
- Read latency: 1 cycle; out shows mem[addr] immediately after the rising edge on which READ is sampled, and holds until the next READ edge or reset.
- Read-after-write to the same address on consecutive cycles returns the newly written data.
- Back-to-back READs to different addresses update out every cycle.
- Outputs never change combinationally with inputs.

## Configuration
- MEMORY_DRIVER_WRITE_THROUGH_EN defined: on a WRITE edge, out is also loaded with the data being written (write-through echo); memory behaviour is unchanged.
- Undefined (default): WRITE leaves out unchanged; out changes only on READ or reset.

## Test plan
- Reset: assert i_reset with inputs at X -> out = 0x00; READ of every address 0..7 after release -> 0x00 each.
- Write/read sequence: WRITE 0x65@0, 0x6C@1, 0x69@2, 0x61@3, 0x73@4, one IDLE cycle, then READ 0..4 -> out = 0x65, 0x6C, 0x69, 0x61, 0x73 on successive cycles.
- Idle hold: after READ@1 (0x6C), hold select=0 with varying addr/data/operation for 5 cycles -> out stays 0x6C, memory unchanged on re-read.
- Write does not disturb out (macro undefined): READ@0 -> 0x65, then WRITE 0xFF@0 -> out stays 0x65; next READ@0 -> 0xFF. With the macro defined, out = 0xFF right after the WRITE edge.
- Overwrite and neighbour isolation: WRITE 0x55@1 then 0xAA@1 -> READ@1 = 0xAA; READ@0 and @2 unchanged.
- Reset mid-operation: assert i_reset asynchronously between edges during a READ burst -> out = 0x00 immediately; all words read back 0x00.
